adder: RTL and testbench

ADDER -- requirements
Module: adder

---
 rtl/adder.sv | 102 ++++++++++
 tb/tb_adder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/adder.sv
// Registered WIDTH-bit add/subtract unit with carry-out, signed overflow and one-cycle latency.
// Define ADDER_SAT_EN to clamp signed-overflow results to the most positive/negative value.
module adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    // Handshake: a, b, cin and sub are taken on every rising edge where in_valid=1;
    // there is no ready, so nothing is ever refused. out_valid is in_valid delayed
    // one cycle and marks the cycle in which sum/cout/ovf first show that result.

    localparam int LEVELS = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] bit_gen;
    logic [WIDTH-1:0] bit_prop;
    logic [WIDTH:0]   grp_gen;
    logic [WIDTH:0]   grp_prop;
    logic [WIDTH:0]   nxt_gen;
    logic [WIDTH:0]   nxt_prop;
    logic [WIDTH-1:0] raw_sum;
    logic             raw_cout;
    logic             raw_ovf;
    logic [WIDTH-1:0] res_sum;
    logic [WIDTH-1:0] sat_max;
    logic [WIDTH-1:0] sat_min;

    assign b_eff    = sub ? ~b : b;
    assign bit_gen  = a & b_eff;
    assign bit_prop = a ^ b_eff;
    assign sat_max  = {1'b0, {(WIDTH-1){1'b1}}};
    assign sat_min  = {1'b1, {(WIDTH-1){1'b0}}};

    // Kogge-Stone prefix over WIDTH+1 positions: position 0 carries cin as a pure
    // generate, position j+1 is operand bit j. After the last level grp_gen[j] is
    // the carry into bit j and grp_gen[WIDTH] is the carry out of the top bit.
    always_comb begin
        grp_gen  = {bit_gen, cin};
        grp_prop = {bit_prop, 1'b0};
        nxt_gen  = '0;
        nxt_prop = '0;
        for (int k = 0; k < LEVELS; k++) begin
            for (int i = 0; i <= WIDTH; i++) begin
                if (i >= (1 << k)) begin
                    nxt_gen[i]  = grp_gen[i] | (grp_prop[i] & grp_gen[i - (1 << k)]);
                    nxt_prop[i] = grp_prop[i] & grp_prop[i - (1 << k)];
                end else begin
                    nxt_gen[i]  = grp_gen[i];
                    nxt_prop[i] = grp_prop[i];
                end
            end
            grp_gen  = nxt_gen;
            grp_prop = nxt_prop;
        end
    end

    assign raw_sum  = bit_prop ^ grp_gen[WIDTH-1:0];
    assign raw_cout = grp_gen[WIDTH];
    assign raw_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (raw_sum[WIDTH-1] != a[WIDTH-1]);

`ifdef ADDER_SAT_EN
    // On overflow both operands share a sign, and that sign is the true result's sign.
    always_comb begin
        res_sum = raw_sum;
        if (raw_ovf) begin
            res_sum = a[WIDTH-1] ? sat_min : sat_max;
        end
    end
`else
    always_comb begin
        res_sum = raw_sum;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= res_sum;
                cout <= raw_cout;
                ovf  <= raw_ovf;
            end
        end
    end

endmodule

// File: tb/tb_adder.sv
// Directed-vector and streaming bench for the registered add/subtract unit (WIDTH=8).
module tb_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         out_valid;

    int n_checks = 0;
    int n_fails  = 0;

    logic [W+1:0] exp_q[$];

    adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin), .sub(sub),
        .sum(sum), .cout(cout), .ovf(ovf), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc, input logic vs);
        in_valid = v;
        a        = va;
        b        = vb;
        cin      = vc;
        sub      = vs;
    endtask

    // Reference model: {ovf, cout, sum}, from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         v;
        be   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, mc};
        s    = full[W-1:0];
        v    = (ma[W-1] == be[W-1]) && (s[W-1] != ma[W-1]);
`ifdef ADDER_SAT_EN
        if (v) s = ma[W-1] ? 8'h80 : 8'h7F;
`endif
        return {v, full[W], s};
    endfunction

    initial begin
        logic [W+1:0] e;
        logic [W-1:0] hold_sum;

`ifdef ADDER_SAT_EN
        vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[1] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[3] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1};
`else
        vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1};
`endif
        vecs[4] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[8] = '{8'h05, 8'h03, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[9] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};

        // Reset held with a valid input presented: nothing must be accepted.
        rst = 1'b1;
        drive(1'b1, 8'h55, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_sum", 64'(sum), 64'h00);
        check("reset_cout", 64'(cout), 64'h0);
        check("reset_ovf", 64'(ovf), 64'h0);
        check("reset_out_valid", 64'(out_valid), 64'h0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_accept_sum", 64'(sum), 64'h55);
        check("first_accept_valid", 64'(out_valid), 64'h1);

        // Directed table, applied back to back.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_sum", i), 64'(sum), 64'(vecs[i].e_sum));
            check($sformatf("vec%0d_cout", i), 64'(cout), 64'(vecs[i].e_cout));
            check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].e_ovf));
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'h1);
        end

        // Idle cycles must hold the last result and drop out_valid.
        hold_sum = vecs[9].e_sum;
        @(negedge clk);
        drive(1'b0, 8'hAA, 8'h11, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("idle_sum_hold", 64'(sum), 64'(hold_sum));
        check("idle_cout_hold", 64'(cout), 64'(vecs[9].e_cout));
        check("idle_out_valid", 64'(out_valid), 64'h0);

        // 100 random back-to-back inputs against the model.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            drive(1'b1, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            exp_q.push_back(model(a, b, cin, sub));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("stream%0d_sum", i), 64'(sum), 64'(e[W-1:0]));
            check($sformatf("stream%0d_cout", i), 64'(cout), 64'(e[W]));
            check($sformatf("stream%0d_ovf", i), 64'(ovf), 64'(e[W+1]));
            check($sformatf("stream%0d_valid", i), 64'(out_valid), 64'h1);
        end

        // Asynchronous reset asserted between edges, in the middle of a stream.
        @(negedge clk);
        drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_async_sum", 64'(sum), 64'h46);
        #2;
        rst = 1'b1;
        #1;
        check("async_sum", 64'(sum), 64'h00);
        check("async_cout", 64'(cout), 64'h0);
        check("async_ovf", 64'(ovf), 64'h0);
        check("async_out_valid", 64'(out_valid), 64'h0);
        @(posedge clk);
        #1;
        check("rst_hold_sum", 64'(sum), 64'h00);
        check("rst_hold_valid", 64'(out_valid), 64'h0);

        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 8'h05, 8'h07, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("post_rst_sum", 64'(sum), 64'hFE);
        check("post_rst_valid", 64'(out_valid), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
